// File: rtl/fp_class_pkg.sv
// Shared constants, the S1 decode-flag bundle and the one-hot class encoder
// for the FCLASS pipeline.
package fp_class_pkg;

    // Bit positions of the RISC-V FCLASS result mask
    localparam int CLS_NEG_INF  = 0;
    localparam int CLS_NEG_NORM = 1;
    localparam int CLS_NEG_SUB  = 2;
    localparam int CLS_NEG_ZERO = 3;
    localparam int CLS_POS_ZERO = 4;
    localparam int CLS_POS_SUB  = 5;
    localparam int CLS_POS_NORM = 6;
    localparam int CLS_POS_INF  = 7;
    localparam int CLS_SNAN     = 8;
    localparam int CLS_QNAN     = 9;
    localparam int CLS_W        = 10;

    // Operand format select
    localparam logic FMT_S = 1'b0;
    localparam logic FMT_D = 1'b1;

    // Fields captured in S1; everything S2 needs to pick the class bit.
    // unboxed marks a single-precision operand whose upper half is not all
    // ones, which must be treated as the canonical quiet NaN.
    typedef struct packed {
        logic sign;
        logic exp_max;
        logic exp_zero;
        logic man_zero;
        logic man_msb;
        logic unboxed;
    } s1_flags_t;

    // Map decoded flags onto exactly one class bit
    function automatic logic [CLS_W-1:0] fp_class_encode(input s1_flags_t f);
        logic [CLS_W-1:0] m;
        m = '0;
        if (f.unboxed) begin
            m[CLS_QNAN] = 1'b1;
        end else if (f.exp_max) begin
            if (f.man_zero) begin
                if (f.sign) m[CLS_NEG_INF] = 1'b1;
                else        m[CLS_POS_INF] = 1'b1;
            end else begin
                // NaN sign is irrelevant; mantissa MSB picks quiet vs signalling
                if (f.man_msb) m[CLS_QNAN] = 1'b1;
                else           m[CLS_SNAN] = 1'b1;
            end
        end else if (f.exp_zero) begin
            if (f.man_zero) begin
                if (f.sign) m[CLS_NEG_ZERO] = 1'b1;
                else        m[CLS_POS_ZERO] = 1'b1;
            end else begin
                if (f.sign) m[CLS_NEG_SUB] = 1'b1;
                else        m[CLS_POS_SUB] = 1'b1;
            end
        end else begin
            if (f.sign) m[CLS_NEG_NORM] = 1'b1;
            else        m[CLS_POS_NORM] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/fp_classify_pipe_if.sv
// Request/response bundle of the FCLASS pipeline.
//
// Handshake: on each side a transfer happens at a rising clock edge where
// valid && ready are both high. A producer holding valid keeps its payload
// stable until the transfer; ready may depend combinationally on downstream
// ready, valid never depends on ready. flush is a synchronous kill of
// everything in flight and travels with the request side.
interface fp_classify_pipe_if #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic             in_fmt;
    logic [XLEN-1:0]  in_data;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_class;
    logic [TAG_W-1:0] out_tag;

    // Requester / result consumer side
    modport master (
        output flush, in_valid, in_fmt, in_data, in_tag, out_ready,
        input  in_ready, out_valid, out_class, out_tag
    );

    // Classifier side
    modport slave (
        input  flush, in_valid, in_fmt, in_data, in_tag, out_ready,
        output in_ready, out_valid, out_class, out_tag
    );
endinterface

// File: rtl/fp_class_decode.sv
// Combinational field decode ahead of S1: selects S or D field positions,
// reduces exponent/mantissa to flags and performs the NaN-box check.
module fp_class_decode
    import fp_class_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int HAS_D = 1
) (
    input  logic            i_fmt,
    input  logic [XLEN-1:0] i_data,
    output s1_flags_t       o_flags
);

    logic [63:0] w_d64;
    logic        w_boxed;
    logic        w_fmt_d;

    // Present a 64-bit view of the operand; the box check only exists when
    // there is an upper half to check.
    generate
        if (XLEN >= 64) begin : g_wide
            assign w_d64   = i_data[63:0];
            assign w_boxed = &i_data[63:32];
        end else begin : g_narrow
            assign w_d64   = {{(64-XLEN){1'b0}}, i_data};
            assign w_boxed = 1'b1;
        end
    endgenerate

    // Without double support the format bit is ignored and S is assumed
    assign w_fmt_d = (HAS_D != 0) && (XLEN >= 64) && (i_fmt == FMT_D);

    // Extract sign/exponent/mantissa flags for the selected format
    always_comb begin
        o_flags = '0;
        if (w_fmt_d) begin
            o_flags.sign     = w_d64[63];
            o_flags.exp_max  = &w_d64[62:52];
            o_flags.exp_zero = ~|w_d64[62:52];
            o_flags.man_zero = ~|w_d64[51:0];
            o_flags.man_msb  = w_d64[51];
            o_flags.unboxed  = 1'b0;
        end else begin
            o_flags.sign     = w_d64[31];
            o_flags.exp_max  = &w_d64[30:23];
            o_flags.exp_zero = ~|w_d64[30:23];
            o_flags.man_zero = ~|w_d64[22:0];
            o_flags.man_msb  = w_d64[22];
            o_flags.unboxed  = ~w_boxed;
        end
    end

endmodule

// File: rtl/fp_classify_pipe.sv
// Two-stage FCLASS pipeline: S1 registers the decoded flags, S2 registers the
// one-hot class. Each stage carries a valid bit and the request tag; the
// whole pipe stalls from the output backwards and can be flushed.
module fp_classify_pipe
    import fp_class_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5,
    parameter int HAS_D = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    fp_classify_pipe_if.slave  bus
);

    logic             r_s1_v;
    s1_flags_t        r_s1_flags;
    logic [TAG_W-1:0] r_s1_tag;

    logic             r_s2_v;
    logic [CLS_W-1:0] r_s2_class;
    logic [TAG_W-1:0] r_s2_tag;

    s1_flags_t        w_dec_flags;
    logic [CLS_W-1:0] w_s2_class_d;
    logic             w_s2_adv;
    logic             w_s1_adv;
    logic             w_s1_load;
    logic             w_s2_load;

    fp_class_decode #(
        .XLEN  (XLEN),
        .HAS_D (HAS_D)
    ) u_decode (
        .i_fmt   (bus.in_fmt),
        .i_data  (bus.in_data),
        .o_flags (w_dec_flags)
    );

    // A stage may take new content when it is empty or its occupant moves on
    assign w_s2_adv  = !r_s2_v || bus.out_ready;
    assign w_s1_adv  = !r_s1_v || w_s2_adv;
    // Payload registers only load on a real transfer into the stage
    assign w_s1_load = bus.in_valid && w_s1_adv && !bus.flush;
    assign w_s2_load = r_s1_v && w_s2_adv && !bus.flush;

    // S1 valid: follows the request when S1 advances, killed by flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_v <= 1'b0;
        end else if (bus.flush) begin
            r_s1_v <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_v <= bus.in_valid;
        end
    end

    // S1 payload: decoded flags and tag of the accepted request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_flags <= '0;
            r_s1_tag   <= '0;
        end else if (w_s1_load) begin
            r_s1_flags <= w_dec_flags;
            r_s1_tag   <= bus.in_tag;
        end
    end

    // One-hot encode of the S1 flags feeding S2
    always_comb begin
        w_s2_class_d = fp_class_encode(r_s1_flags);
    end

    // S2 valid: takes S1's valid when S2 advances, killed by flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_v <= 1'b0;
        end else if (bus.flush) begin
            r_s2_v <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_v <= r_s1_v;
        end
    end

    // S2 payload: class mask and tag, held while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_class <= '0;
            r_s2_tag   <= '0;
        end else if (w_s2_load) begin
            r_s2_class <= w_s2_class_d;
            r_s2_tag   <= r_s1_tag;
        end
    end

    // No skid buffer: ready is a direct function of occupancy and out_ready
    assign bus.in_ready  = w_s1_adv;
    assign bus.out_valid = r_s2_v;
    assign bus.out_class = {{(XLEN-CLS_W){1'b0}}, r_s2_class};
    assign bus.out_tag   = r_s2_tag;

endmodule
